bit_stuffer: RTL and testbench
==============================

Name: bit_stuffer

Overview:
- Serial stage directly downstream of the CRC appender in the USB host transmit path.
- Consumes the CRC block's bit stream (outb/sending) and inserts a 0 after every run of RUN_LEN consecutive 1s.
- While inserting, it asserts a pause back to the CRC block so no payload bit is lost.
- Output feeds the NRZI encoder.

Parameters:
RUN_LEN, 6, number of consecutive 1s that forces a stuffed 0 (USB: 6)

Ports:
clk  input  1  system clock
rst_L  input  1  asynchronous reset, active-low
clear  input  1  synchronous abort; returns block to IDLE
inb  input  1  upstream serial bit (CRC block outb)
recving  input  1  upstream bit valid (CRC block sending)
stuff_pause  output  1  to CRC block pause_out; upstream holds current inb this cycle
outb  output  1  serial bit to NRZI encoder
sending  output  1  outb valid this cycle

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state IDLE, ones count 0. Outputs are combinational from state and inputs; with recving=0 in IDLE, outb=0, sending=0, stuff_pause=0.
- Latency: zero. A passed bit appears on outb in the same cycle it is presented.
- Ones counter: width $clog2(RUN_LEN+1), saturates by construction and never exceeds RUN_LEN-1 at a clock edge.
- States: IDLE, PASS, STUFF.

State actions:
- IDLE:
  - recving=1: outb=inb, sending=1, update counter as in PASS; next PASS, or STUFF if this bit completes the run.
  - recving=0: outputs 0, count cleared, stay IDLE.
- PASS:
  - recving=1: outb=inb, sending=1. inb=1 increments the count; inb=0 clears it.
  - If inb=1 and count==RUN_LEN-1: count cleared, next STUFF.
  - recving=0: outputs 0, count cleared, next IDLE.
- STUFF:
  - outb=0, sending=1, stuff_pause=1, count held at 0, inb ignored.
  - Next PASS if recving=1, else IDLE.
  - The stuffed bit is emitted even if the run's final 1 was the last packet bit (recving already low). End-of-packet stuffing is mandatory.

Handshake rules:
- Upstream must present the same inb with recving=1 in the cycle after a stuff_pause cycle.
- The CRC block satisfies this by freezing its shift and count on pause_out.
- stuff_pause is never asserted for two consecutive cycles.
- stuff_pause is never asserted outside STUFF.

Boundary and override behaviour:
- A 0 bit at count RUN_LEN-1 clears the count; no stuff.
- A stuffed 0 itself resets the run, so the next RUN_LEN 1s stuff again.
- clear has priority over everything: that cycle, outputs 0 and stuff_pause 0; next state IDLE, count 0.
- rst_L low mid-STUFF: immediate IDLE, outputs to reset values; no stuffed bit is emitted.
- recving dropping then rising without an IDLE cycle in between is legal. The count is already cleared on the drop cycle.

Decomposition:
- Shared package usb_pkg: bit_stuff_state_t enum {IDLE, PASS, STUFF}; constant USB_STUFF_RUN = 6 (default for RUN_LEN).
- Reuse the existing counter module for the ones count: inc_cnt, clr_cnt, up=1, cnt.
- No new sub-module. One always_ff for state, one always_comb for next-state and outputs.

Test Plan:
- Packet 8'b1111_1111 (recving 8 bits), bench honours the pause. Required:
  - outb/sending stream 1111110 11 over 9 cycles.
  - stuff_pause high only in cycle 7.
  - inb held for cycle 8.
- Packet 6'b111110. Required: outputs 111110 in 6 cycles, stuff_pause never asserted, sending low in cycle 7.
- Packet of exactly six 1s, recving drops after bit 6. Required: outb 1111110, sending high 7 cycles, stuff_pause in cycle 7, then IDLE with sending=0.
- Packet of twelve 1s. Required: 1111110 1111110 (14 cycles), stuff_pause in cycles 7 and 14.
- Four 1s, then clear=1 in cycle 5, then new packet 111 with recving. Required:
  - Outputs 0 in the clear cycle.
  - Count restarts; no stuff in the following 111 even though 7 total 1s were presented.
- Five 1s, then rst_L low for 1 cycle mid-stream. Required:
  - outb, sending and stuff_pause go 0 asynchronously.
  - Next packet of six 1s stuffs after bit 6, not earlier.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB transmit-path types and constants.
// Holds the bit-stuffer state encoding and the USB stuffing run length.
// No logic; imported by the transmit-path blocks.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    STUFF = 2'd2
  } bit_stuff_state_t;

  // USB inserts a 0 after six consecutive 1s.
  localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/counter.sv
// Generic up/down counter with synchronous clear (clear wins over increment).
// Latency: cnt updates on the clock edge after inc_cnt/clr_cnt.
// Backpressure: none; counts whenever inc_cnt is high.
//
// Ports:
//   clk      clock
//   rst_L    asynchronous reset, active-low (count to 0)
//   inc_cnt  step the count this cycle
//   clr_cnt  return the count to 0 this cycle
//   up       1: count up, 0: count down
//   cnt      current count
module counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             inc_cnt,
  input  logic             clr_cnt,
  input  logic             up,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (inc_cnt) begin
      r_cnt <= up ? r_cnt + 1'b1 : r_cnt - 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s.
// Latency: zero; a passed bit appears on outb in the cycle it is presented.
// Backpressure: stuff_pause for one cycle while the stuffed 0 goes out; upstream holds inb.
//
// Ports:
//   clk          clock
//   rst_L        asynchronous reset, active-low
//   clear        synchronous abort back to IDLE (highest priority)
//   inb          upstream serial bit (CRC appender outb)
//   recving      inb valid this cycle (CRC appender sending)
//   stuff_pause  upstream must hold the current inb this cycle
//   outb         serial bit to the NRZI encoder
//   sending      outb valid this cycle
module bit_stuffer
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_STUFF_RUN
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clear,
  input  logic inb,
  input  logic recving,
  output logic stuff_pause,
  output logic outb,
  output logic sending
);

  localparam int                CNT_W    = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_LEN - 1);

  bit_stuff_state_t r_state;
  bit_stuff_state_t w_next_state;

  logic             w_inc_cnt;
  logic             w_clr_cnt;
  logic [CNT_W-1:0] w_ones_cnt;

  // Ones-run counter. It is cleared on the bit that completes a run, so it
  // never holds more than RUN_LEN-1 at a clock edge.
  counter #(
    .WIDTH (CNT_W)
  ) u_ones_cnt (
    .clk     (clk),
    .rst_L   (rst_L),
    .inc_cnt (w_inc_cnt),
    .clr_cnt (w_clr_cnt),
    .up      (1'b1),
    .cnt     (w_ones_cnt)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_inc_cnt    = 1'b0;
    w_clr_cnt    = 1'b0;
    outb         = 1'b0;
    sending      = 1'b0;
    stuff_pause  = 1'b0;

    if (!rst_L) begin
      // Outputs are combinational from the inputs, so hold them quiet while
      // reset is asserted even if upstream still drives recving.
      w_next_state = IDLE;
    end else if (clear) begin
      w_next_state = IDLE;
      w_clr_cnt    = 1'b1;
    end else begin
      unique case (r_state)
        IDLE, PASS: begin
          if (recving) begin
            outb    = inb;
            sending = 1'b1;
            if (!inb) begin
              w_clr_cnt    = 1'b1;
              w_next_state = PASS;
            end else if (w_ones_cnt == RUN_LAST) begin
              // This 1 completes the run: the stuffed 0 goes out next cycle.
              w_clr_cnt    = 1'b1;
              w_next_state = STUFF;
            end else begin
              w_inc_cnt    = 1'b1;
              w_next_state = PASS;
            end
          end else begin
            w_clr_cnt    = 1'b1;
            w_next_state = IDLE;
          end
        end
        STUFF: begin
          // Emitted even when recving has already dropped: a run ending on
          // the last packet bit still needs its stuffed 0.
          outb         = 1'b0;
          sending      = 1'b1;
          stuff_pause  = 1'b1;
          w_clr_cnt    = 1'b1;
          w_next_state = recving ? PASS : IDLE;
        end
        default: begin
          w_clr_cnt    = 1'b1;
          w_next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stuffer.sv
module tb_bit_stuffer;

  localparam int RUN = 6;

  logic clk;
  logic rst_L;
  logic clear;
  logic inb;
  logic recving;
  logic stuff_pause;
  logic outb;
  logic sending;

  int n_cmp;
  int n_fail;

  bit tx_q[$];
  bit obs_q[$];
  int obs_p_q[$];
  bit exp_q[$];
  int exp_p_q[$];
  int end_cyc;

  bit_stuffer #(.RUN_LEN(RUN)) dut (
    .clk         (clk),
    .rst_L       (rst_L),
    .clear       (clear),
    .inb         (inb),
    .recving     (recving),
    .stuff_pause (stuff_pause),
    .outb        (outb),
    .sending     (sending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk the packet, counting 1s; every RUN-th consecutive 1 is
  // followed by an inserted 0. Pause cycles are the (1-based) output
  // positions of the inserted 0s.
  task automatic build_expected();
    int run;
    run = 0;
    exp_q.delete();
    exp_p_q.delete();
    foreach (tx_q[i]) begin
      exp_q.push_back(tx_q[i]);
      if (tx_q[i]) begin
        run++;
        if (run == RUN) begin
          exp_q.push_back(1'b0);
          exp_p_q.push_back(exp_q.size());
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  // Upstream model: presents tx_q bit by bit, holding the bit whenever
  // stuff_pause is seen. Records the output stream, the pause cycles and the
  // first cycle with sending low after the packet. Entered and left at
  // posedge+1.
  task automatic drive_pkt();
    int  idx;
    int  cyc;
    bit  adv;
    bit  done;
    idx = 0;
    cyc = 0;
    done = 1'b0;
    end_cyc = -1;
    obs_q.delete();
    obs_p_q.delete();
    while (!done && cyc < 300) begin
      if (idx < tx_q.size()) begin
        recving = 1'b1;
        inb     = tx_q[idx];
      end else begin
        recving = 1'b0;
        inb     = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (sending) obs_q.push_back(outb);
      if (stuff_pause) obs_p_q.push_back(cyc);
      adv = recving && !stuff_pause;
      if (!sending && idx >= tx_q.size()) begin
        done    = 1'b1;
        end_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (adv) idx++;
    end
    recving = 1'b0;
    inb     = 1'b0;
  endtask

  task automatic test_reset();
    rst_L   = 1'b0;
    clear   = 1'b0;
    inb     = 1'b0;
    recving = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({outb, sending, stuff_pause} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=000", {outb, sending, stuff_pause});
    end
    recving = 1'b1;
    inb     = 1'b1;
    #1;
    n_cmp++;
    if ({outb, sending, stuff_pause} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_recving_outputs got=%b want=000", {outb, sending, stuff_pause});
    end
    recving = 1'b0;
    inb     = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({outb, sending, stuff_pause} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_outputs got=%b want=000", {outb, sending, stuff_pause});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] pat [4];
    int          len [4];
    pat[0] = 16'h00FF; len[0] = 8;
    pat[1] = 16'h003E; len[1] = 6;
    pat[2] = 16'h003F; len[2] = 6;
    pat[3] = 16'h0FFF; len[3] = 12;
    for (int p = 0; p < 4; p++) begin
      tx_q.delete();
      for (int i = len[p] - 1; i >= 0; i--) tx_q.push_back(pat[p][i]);
      build_expected();
      drive_pkt();
      n_cmp++;
      if (obs_q.size() != exp_q.size() || end_cyc != exp_q.size() + 1) begin
        n_fail++;
        $display("FAIL dir%0d_len got=%0d end=%0d want=%0d end=%0d", p, obs_q.size(), end_cyc, exp_q.size(), exp_q.size() + 1);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL dir%0d_bit%0d got=%b want=%b", p, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (obs_p_q != exp_p_q) begin
        n_fail++;
        $display("FAIL dir%0d_pause got=%p want=%p", p, obs_p_q, exp_p_q);
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) begin
      recving = 1'b1;
      inb     = 1'b1;
      @(posedge clk);
      #1;
    end
    clear = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({outb, sending, stuff_pause} !== 3'b000) begin
      n_fail++;
      $display("FAIL clear_cycle got=%b want=000", {outb, sending, stuff_pause});
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({outb, sending, stuff_pause} !== 3'b110) begin
        n_fail++;
        $display("FAIL clear_restart%0d got=%b want=110", i, {outb, sending, stuff_pause});
      end
      @(posedge clk);
      #1;
    end
    // Abort while a stuff is pending: no stuffed bit follows.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    clear = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sending, stuff_pause} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_in_stuff got=%b want=00", {sending, stuff_pause});
    end
    @(posedge clk);
    #1;
    clear   = 1'b0;
    recving = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sending, stuff_pause} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_after got=%b want=00", {sending, stuff_pause});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      recving = 1'b1;
      inb     = 1'b1;
      @(posedge clk);
      #1;
    end
    #2;
    rst_L = 1'b0;
    #1;
    n_cmp++;
    if ({outb, sending, stuff_pause} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset got=%b want=000", {outb, sending, stuff_pause});
    end
    @(posedge clk);
    #1;
    rst_L   = 1'b1;
    recving = 1'b0;
    inb     = 1'b0;
    @(posedge clk);
    #1;
    tx_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(1'b1);
    build_expected();
    drive_pkt();
    n_cmp++;
    if (obs_q != exp_q || obs_p_q != exp_p_q || end_cyc != 8) begin
      n_fail++;
      $display("FAIL post_reset_six got=%p pause=%p end=%0d want=%p pause=%p end=8", obs_q, obs_p_q, end_cyc, exp_q, exp_p_q);
    end
  endtask

  task automatic test_back_to_back();
    bit pa [$];
    bit pb [$];
    pa = '{1, 1, 1, 1};       pb = '{1, 1, 0, 1};
    for (int k = 0; k < 2; k++) begin
      tx_q = (k == 0) ? pa : '{1, 1, 1, 1, 1, 1};
      build_expected();
      drive_pkt();
      n_cmp++;
      if (obs_q != exp_q || obs_p_q != exp_p_q) begin
        n_fail++;
        $display("FAIL b2b%0d_a got=%p pause=%p want=%p pause=%p", k, obs_q, obs_p_q, exp_q, exp_p_q);
      end
      // Second packet starts right after the single drop cycle.
      tx_q = (k == 0) ? pb : '{1, 1, 1, 1, 1, 1, 1};
      build_expected();
      drive_pkt();
      n_cmp++;
      if (obs_q != exp_q || obs_p_q != exp_p_q || end_cyc != exp_q.size() + 1) begin
        n_fail++;
        $display("FAIL b2b%0d_b got=%p pause=%p want=%p pause=%p", k, obs_q, obs_p_q, exp_q, exp_p_q);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 25; p++) begin
      n = $urandom_range(1, 30);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(($urandom % 5) != 0);
      build_expected();
      drive_pkt();
      n_cmp++;
      if (obs_q != exp_q || end_cyc != exp_q.size() + 1) begin
        n_fail++;
        $display("FAIL rnd%0d_stream got=%p end=%0d want=%p end=%0d", p, obs_q, end_cyc, exp_q, exp_q.size() + 1);
      end
      n_cmp++;
      if (obs_p_q != exp_p_q) begin
        n_fail++;
        $display("FAIL rnd%0d_pause got=%p want=%p", p, obs_p_q, exp_p_q);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
